// File: rtl/apb_mem_slave.sv
// APB completer backed by a byte-wide memory. It inserts a fixed number of
// wait states and flags out-of-range addresses on PSLVERR.
module apb_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [7:0]        wdata_r;
  logic [7:0]        mem_r [MEM_DEPTH];

  logic              setup_s;
  logic              ready_s;
  logic              err_s;
  logic              commit_s;
  logic [IDX_W-1:0]  idx_s;
  logic [7:0]        rdata_s;

  // Decode of the current phase, error flag, commit strobe and read mux.
  always_comb begin
    setup_s  = PSEL && !PENABLE;
    ready_s  = (state_r == ST_ACCESS) && (cnt_r == CNT_ZERO);
    err_s    = ({1'b0, addr_r} >= DEPTH_LIM);
    idx_s    = addr_r[IDX_W-1:0];
    commit_s = ready_s && PSEL && PENABLE && write_r && !err_s;
    if (ready_s && !write_r && !err_s) begin
      rdata_s = mem_r[idx_s];
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign PREADY  = ready_s;
  assign PSLVERR = ready_s & err_s;
  assign PRDATA  = rdata_s;

  // Transfer FSM: a setup phase in either state (re)starts a transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      addr_r  <= ADDR_W'(0);
      write_r <= 1'b0;
      wdata_r <= 8'h00;
    end else if (setup_s) begin
      state_r <= ST_ACCESS;
      cnt_r   <= WAIT_LOAD;
      addr_r  <= PADDR;
      write_r <= PWRITE;
      wdata_r <= PWDATA;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Memory array, cleared on reset and written only on a clean completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (commit_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized bench for apb_mem_slave against a transfer-level memory model;
// a second zero-wait instance covers the WAIT_CYCLES=0 build.
module tb_apb_mem_slave;

  localparam int WAIT_N = 2;
  localparam int DEPTH  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       psel0, penable0, pwrite0;
  logic [7:0] paddr0, pwdata0, prdata0;
  logic       pready0, pslverr0;

  int errors = 0;
  int checks = 0;
  logic [7:0] model [256];

  logic       zw_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] zw_addr [4] = '{8'h05, 8'h03, 8'h03, 8'h45};
  logic [7:0] zw_data [4] = '{8'h00, 8'hC3, 8'h00, 8'h00};
  logic [7:0] zw_rd   [4] = '{8'h00, 8'h00, 8'hC3, 8'h00};
  logic       zw_err  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_W(8), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAIT_N)) dut (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_mem_slave #(.ADDR_W(8), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0),
    .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    psel = 1'b0;
    penable = 1'b0;
    repeat (n) @(negedge clk);
    check("idle_pready", {31'd0, pready}, 32'd0);
  endtask

  // Full transfer starting at a negedge; returns at the negedge after completion.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      input logic restart, input logic scramble);
    int         acc;
    logic       exp_err;
    logic [7:0] exp_rd;
    if (restart) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'($urandom_range(0, 63)); pwdata = 8'($urandom);
      @(negedge clk);
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    if (scramble) begin
      pwrite = 1'($urandom); paddr = 8'($urandom); pwdata = 8'($urandom);
    end
    acc = 1;
    while (pready !== 1'b1 && acc <= 20) begin
      @(negedge clk);
      acc++;
    end
    exp_err = (int'(addr) >= DEPTH);
    exp_rd  = (!wr && !exp_err) ? model[addr] : 8'h00;
    check("latency", acc, WAIT_N + 1);
    check("pslverr", {31'd0, pslverr}, {31'd0, exp_err});
    check("prdata", {24'd0, prdata}, {24'd0, exp_rd});
    @(negedge clk);
    if (wr && !exp_err) model[addr] = data;
  endtask

  task automatic abort_xfer(input logic [7:0] addr, input logic [7:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_pready", {31'd0, pready}, 32'd0);
  endtask

  // Access phase with no preceding setup while idle must be ignored.
  task automatic noise;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 8'($urandom_range(0, 63)); pwdata = 8'($urandom);
    repeat (2) begin
      @(negedge clk);
      check("noise_pready", {31'd0, pready}, 32'd0);
    end
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int         acc;
    int         r;
    logic [7:0] a;
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = 8'h00; pwdata0 = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_prdata", {24'd0, prdata}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait instance: PREADY in the first access cycle, back-to-back.
    for (int k = 0; k < 4; k++) begin
      psel0 = 1'b1; penable0 = 1'b0; pwrite0 = zw_wr[k];
      paddr0 = zw_addr[k]; pwdata0 = zw_data[k];
      @(negedge clk);
      penable0 = 1'b1;
      check("zw_pready", {31'd0, pready0}, 32'd1);
      check("zw_pslverr", {31'd0, pslverr0}, {31'd0, zw_err[k]});
      check("zw_prdata", {24'd0, prdata0}, {24'd0, zw_rd[k]});
      @(negedge clk);
    end
    psel0 = 1'b0;
    penable0 = 1'b0;

    xfer(1'b1, 8'h10, 8'h5A, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    idle(1);
    xfer(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    xfer(1'b1, 8'd63, 8'hFF, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'd63, 8'h00, 1'b0, 1'b0);
    idle(1);
    xfer(1'b1, 8'h50, 8'hAA, 1'b0, 1'b0);
    xfer(1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    abort_xfer(8'h20, 8'h33);
    xfer(1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    noise();
    xfer(1'b0, paddr, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 8'h08, 8'h3C, 1'b0, 1'b1);
    xfer(1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 8'h12, 8'h99, 1'b1, 1'b0);
    xfer(1'b0, 8'h12, 8'h00, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 79));
      if (r == 0) abort_xfer(a, 8'($urandom));
      else if (r == 1) noise();
      else xfer(1'($urandom), a, 8'($urandom), r == 2, r == 3);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Asynchronous reset while PREADY is high on a pending write.
    xfer(1'b1, 8'h30, 8'h11, 1'b0, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 8'h77;
    @(negedge clk);
    penable = 1'b1;
    acc = 1;
    while (pready !== 1'b1 && acc <= 20) begin
      @(negedge clk);
      acc++;
    end
    check("rst_latency", acc, WAIT_N + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pready", {31'd0, pready}, 32'd0);
    check("async_rst_pslverr", {31'd0, pslverr}, 32'd0);
    psel = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
